pwm_decoder: RTL and testbench
==============================

PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the period and high-time counters (range 8..24).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, giving the clock cycles without a rising edge before a static level is declared (TIMEOUT < 2^CNT_W).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port pwm_in, input, 1 bit: the asynchronous PWM signal to measure.
REQ-006 The block SHALL have port period_o, output, CNT_W bits: the last captured period in clk cycles.
REQ-007 The block SHALL have port high_o, output, CNT_W bits: the last captured high time in clk cycles.
REQ-008 The block SHALL have port duty_o, output, 4 bits: the duty cycle in tenths (0..10).
REQ-009 The block SHALL have port duty_valid_o, output, 1 bit: a one-cycle strobe marking a new duty_o.
REQ-010 The block SHALL have port timeout_o, output, 1 bit: a level flag meaning no edge was seen within TIMEOUT cycles.
REQ-011 The block SHALL have port overrun_o, output, 1 bit: a one-cycle strobe marking a measurement dropped because the divider was busy.

Function
REQ-012 pwm_in SHALL pass through a 2-FF synchronizer; "s" denotes the synchronized level and "s_prev" its value one cycle earlier.
REQ-013 A rising edge SHALL be detected in any cycle where s=1 and s_prev=0.
REQ-014 On each edge, cnt_p SHALL load 1; otherwise it SHALL increment, saturating at 2^CNT_W-1.
REQ-015 On each edge, cnt_h SHALL load 1; otherwise it SHALL increment when s=1 and hold when s=0, saturating likewise.
REQ-016 The first edge after reset or after timeout SHALL only arm capture; it SHALL NOT update any output.
REQ-017 On each armed edge, cnt_p and cnt_h SHALL be captured into period_o and high_o (example: 10-cycle period with 5 high cycles gives 10/5).
REQ-018 The divider FSM SHALL have states IDLE, DIV, DONE; an armed edge in IDLE SHALL cause IDLE->DIV.
REQ-019 DIV SHALL last exactly 4 cycles, one restoring step per cycle testing 8P, 4P, 2P, P against 10*H, yielding duty_o = floor(10*high_o/period_o).
REQ-020 After DIV the FSM SHALL enter DONE for 1 cycle, asserting duty_valid_o and updating duty_o, then return to IDLE.
REQ-021 Latency: for an edge in cycle T, duty_valid_o SHALL be asserted in cycle T+5.
REQ-022 An armed edge while the FSM is in DIV or DONE SHALL be discarded (captured registers unchanged) and overrun_o SHALL pulse in the same cycle.
REQ-023 If cnt_p reaches TIMEOUT, timeout_o SHALL set and capture SHALL disarm; in the same cycle duty_o SHALL become 10 if s=1 else 0, with duty_valid_o pulsing once.
REQ-024 While timeout_o is set, period_o and high_o SHALL hold their values.
REQ-025 The next edge SHALL clear timeout_o and re-arm capture without capturing.
REQ-026 If the timeout condition and an edge occur in the same cycle, the edge SHALL take priority and no timeout SHALL occur.
REQ-027 duty_o SHALL never exceed 10.

Reset
REQ-028 With rst_n low, all outputs SHALL be 0, the FSM SHALL be IDLE, capture SHALL be disarmed, the counters SHALL be 0 and the synchronizer SHALL be 0.
REQ-029 Reset asserted mid-DIV SHALL abort the division with no duty_valid_o pulse.
REQ-030 rst_n SHALL be asserted asynchronously; its release SHALL be sampled at clk.

Configuration
REQ-031 With macro PWM_DECODER_GLITCH_FILTER_EN defined, s SHALL be the 3-sample majority of the synchronized input.
REQ-032 With PWM_DECODER_GLITCH_FILTER_EN defined, single-cycle pulses SHALL be rejected and edge latency SHALL increase by 2 cycles.
REQ-033 With PWM_DECODER_GLITCH_FILTER_EN undefined, s SHALL be the plain synchronizer output and every 1-cycle pulse SHALL be treated as an edge.

Verification
REQ-034 Period 10 with 5 high cycles, steady: after the second edge, period_o=10, high_o=5, duty_o=5, and duty_valid_o SHALL pulse 5 cycles after each edge.
REQ-035 Period 20 with 7 high cycles: duty_o=3 (floor of 3.5); then 20 high cycles (100%) via timeout SHALL give duty_o=10.
REQ-036 pwm_in held high for TIMEOUT cycles: timeout_o=1 and duty_o=10 with one valid pulse; the next edge SHALL clear timeout_o with no capture.
REQ-037 Period 4: the bench SHALL see an overrun_o pulse on alternate edges and no corruption of duty_o.
REQ-038 rst_n low 2 cycles after an edge: no duty_valid_o and all outputs 0.
REQ-039 A 1-cycle glitch inside the low phase SHALL be rejected (no capture) with PWM_DECODER_GLITCH_FILTER_EN defined and SHALL be captured as an edge without it.

Source files
------------

// File: rtl/pwm_decoder.sv
// PWM period/high-time decoder with a 4-step restoring divider for duty in tenths.
// Define PWM_DECODER_GLITCH_FILTER_EN for a 3-sample majority filter on the input.
module pwm_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic [3:0]       duty_o,
  output logic             duty_valid_o,
  output logic             timeout_o,
  output logic             overrun_o
);

  localparam int RW = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic sync1;
  logic sync2;
  logic s;
  logic s_prev;
  logic rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic h1;
  logic h2;
  logic s_maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1    <= 1'b0;
      h2    <= 1'b0;
      s_maj <= 1'b0;
    end else begin
      h1    <= sync2;
      h2    <= h1;
      s_maj <= (sync2 & h1) | (sync2 & h2) | (h1 & h2);
    end
  end

  assign s = s_maj;
`else
  assign s = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;

  logic [CNT_W-1:0] cnt_p;
  logic [CNT_W-1:0] cnt_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p <= '0;
      cnt_h <= '0;
    end else if (rise) begin
      cnt_p <= CNT_W'(1);
      cnt_h <= CNT_W'(1);
    end else begin
      if (cnt_p != CNT_MAX) begin
        cnt_p <= cnt_p + CNT_W'(1);
      end
      if (s && cnt_h != CNT_MAX) begin
        cnt_h <= cnt_h + CNT_W'(1);
      end
    end
  end

  logic armed;
  logic busy;
  logic accept;
  logic to_fire;

  assign busy      = (state_q != IDLE);
  assign accept    = rise & armed & ~busy;
  assign overrun_o = rise & armed & busy;
  // An edge in the same cycle always wins over the timeout.
  assign to_fire   = ~rise & ~timeout_o & (cnt_p == TO_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      timeout_o <= 1'b0;
    end else if (rise) begin
      armed     <= 1'b1;
      timeout_o <= 1'b0;
    end else if (to_fire) begin
      armed     <= 1'b0;
      timeout_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_o <= '0;
      high_o   <= '0;
    end else if (accept) begin
      period_o <= cnt_p;
      high_o   <= cnt_h;
    end
  end

  logic [RW-1:0]    rem_q;
  logic [CNT_W-1:0] den_q;
  logic [3:0]       quo_q;
  logic [1:0]       step_q;
  logic [RW-1:0]    h_ext;
  logic [RW-1:0]    rem_init;
  logic [RW-1:0]    trial;
  logic [1:0]       shamt;
  logic             ge;
  logic [3:0]       q_next;
  logic [3:0]       duty_div;
  logic             div_last;

  assign h_ext    = {4'b0, cnt_h};
  assign rem_init = (h_ext << 3) + (h_ext << 1);
  assign shamt    = 2'd3 - step_q;
  assign trial    = {4'b0, den_q} << shamt;
  assign ge       = (rem_q >= trial);
  assign q_next   = {quo_q[2:0], ge};
  assign duty_div = (q_next > 4'd10) ? 4'd10 : q_next;
  assign div_last = (state_q == DIV) && (step_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
    end else if (accept) begin
      rem_q  <= rem_init;
      den_q  <= cnt_p;
      quo_q  <= '0;
      step_q <= '0;
    end else if (state_q == DIV) begin
      if (ge) begin
        rem_q <= rem_q - trial;
      end
      quo_q  <= q_next;
      step_q <= step_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = DIV;
      DIV:  if (step_q == 2'd3) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_fire) begin
      state_d = IDLE;
    end
  end

  logic [3:0] duty_d;

  always_comb begin
    duty_d = duty_o;
    if (to_fire) begin
      duty_d = s ? 4'd10 : 4'd0;
    end else if (div_last) begin
      duty_d = duty_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_o       <= '0;
      duty_valid_o <= 1'b0;
    end else begin
      duty_o       <= duty_d;
      duty_valid_o <= to_fire | div_last;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: event-level model plus directed scenarios.
// Honours PWM_DECODER_GLITCH_FILTER_EN when defined at compile time.
module tb_pwm_decoder;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 40;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic [3:0]       duty_o;
  logic             duty_valid_o;
  logic             timeout_o;
  logic             overrun_o;

  pwm_decoder #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .period_o    (period_o),
    .high_o      (high_o),
    .duty_o      (duty_o),
    .duty_valid_o(duty_valid_o),
    .timeout_o   (timeout_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit hist [0:4095];
  int r0 = 0;

  function automatic bit pw(input int j);
    if (j < r0 || j < 0) return 1'b0;
    return hist[j];
  endfunction

  // Level seen by the edge detector in cycle j.
  function automatic bit s_at(input int j);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    int c;
    c = int'(pw(j - 3)) + int'(pw(j - 4)) + int'(pw(j - 5));
    return c >= 2;
`else
    return pw(j - 2);
`endif
  endfunction

  bit m_armed;
  bit m_to;
  int m_origin;
  int m_acc;
  int m_period;
  int m_high;
  int m_duty;
  int vq_t[$];
  int vq_d[$];

  always @(negedge clk) begin
    int k;
    int cp;
    int ch;
    bit sk;
    bit e_edge;
    bit e_valid;
    bit e_over;
    bit busy;
    bit tf;
    k = cyc;
    hist[k] = pwm_in;
    if (!rst_n) begin
      r0       = k + 1;
      m_armed  = 1'b0;
      m_to     = 1'b0;
      m_origin = k + 1;
      m_acc    = -1000;
      m_period = 0;
      m_high   = 0;
      m_duty   = 0;
      vq_t.delete();
      vq_d.delete();
      chk("rst_period", int'(period_o), 0);
      chk("rst_high", int'(high_o), 0);
      chk("rst_duty", int'(duty_o), 0);
      chk("rst_valid", int'(duty_valid_o), 0);
      chk("rst_timeout", int'(timeout_o), 0);
      chk("rst_overrun", int'(overrun_o), 0);
    end else begin
      sk     = s_at(k);
      e_edge = sk && !s_at(k - 1);
      cp     = k - m_origin;
      if (cp > CMAX) cp = CMAX;
      ch = 0;
      for (int j = m_origin; j < k; j++) if (s_at(j)) ch++;
      if (ch > CMAX) ch = CMAX;
      e_valid = (vq_t.size() > 0) && (vq_t[0] == k);
      if (e_valid) begin
        m_duty = vq_d[0];
        void'(vq_t.pop_front());
        void'(vq_d.pop_front());
      end
      busy   = (k > m_acc) && (k <= m_acc + 5);
      e_over = e_edge && m_armed && busy;
      chk("period", int'(period_o), m_period);
      chk("high", int'(high_o), m_high);
      chk("duty", int'(duty_o), m_duty);
      chk("valid", int'(duty_valid_o), int'(e_valid));
      chk("timeout", int'(timeout_o), int'(m_to));
      chk("overrun", int'(overrun_o), int'(e_over));
      tf = !e_edge && !m_to && (cp == TIMEOUT);
      if (e_edge) begin
        if (m_armed && !busy) begin
          m_period = cp;
          m_high   = ch;
          m_acc    = k;
          vq_t.push_back(k + 5);
          vq_d.push_back((10 * ch) / cp);
        end
        m_armed  = 1'b1;
        m_to     = 1'b0;
        m_origin = k;
      end else if (tf) begin
        m_to    = 1'b1;
        m_armed = 1'b0;
        vq_t.push_back(k + 1);
        vq_d.push_back(sk ? 10 : 0);
      end
    end
  end

  // ---------------- pulse monitors ----------------
  int n_valid   = 0;
  int n_over    = 0;
  int last_vcyc = -1;

  always @(negedge clk) begin
    if (duty_valid_o) begin
      n_valid   <= n_valid + 1;
      last_vcyc <= cyc;
    end
    if (overrun_o) n_over <= n_over + 1;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit v);
    @(posedge clk);
    #1 pwm_in = v;
  endtask

  task automatic pulses(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++) tick(j < hi);
  endtask

  task automatic ticks(input bit v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  initial begin
    int d2;
    int base_v;
    int base_o;
    int d;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_duty", int'(duty_o), 0);
    chk("lit_rst_to", int'(timeout_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(0, 3);

    // period 10, high 5
    pulses(10, 5, 1);
    base_v = n_valid;
    d2 = cyc + 1;
    pulses(10, 5, 4);
    ticks(0, 3);
    chk("lit_p10_period", int'(period_o), 10);
    chk("lit_p10_high", int'(high_o), 5);
    chk("lit_p10_duty", int'(duty_o), 5);
    chk("lit_p10_nvalid", n_valid - base_v, 4);
    chk("lit_p10_latency", last_vcyc, d2 + 30 + LAT + 5);

    // period 20, high 7, then 100% high into timeout
    pulses(20, 7, 3);
    chk("lit_p20_duty", int'(duty_o), 3);
    chk("lit_p20_period", int'(period_o), 20);
    base_v = n_valid;
    ticks(1, 60);
    chk("lit_to_flag", int'(timeout_o), 1);
    chk("lit_to_duty", int'(duty_o), 10);
    chk("lit_to_period", int'(period_o), 20);
    chk("lit_to_high", int'(high_o), 7);
    chk("lit_to_nvalid", n_valid - base_v, 2);

    // single edge clears timeout without capture
    base_v = n_valid;
    ticks(0, 3);
    ticks(1, 4);
    ticks(0, 6);
    chk("lit_clr_to", int'(timeout_o), 0);
    chk("lit_clr_period", int'(period_o), 20);
    chk("lit_clr_nvalid", n_valid - base_v, 0);

    // period 4: overrun on alternate edges
    base_v = n_valid;
    base_o = n_over;
    pulses(4, 2, 8);
    ticks(0, 8);
    chk("lit_p4_nover", n_over - base_o, 4);
    chk("lit_p4_nvalid", n_valid - base_v, 4);
    chk("lit_p4_duty", int'(duty_o), 5);
    chk("lit_p4_period", int'(period_o), 4);

    // reset during the division
    pulses(10, 5, 2);
    d = cyc + 1;
    ticks(1, 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    base_v = n_valid;
    pwm_in = 1'b0;
    chk("lit_mid_cycle", cyc, d + 5);
    ticks(0, 3);
    chk("lit_midrst_period", int'(period_o), 0);
    chk("lit_midrst_duty", int'(duty_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(0, 10);
    chk("lit_midrst_nvalid", n_valid - base_v, 0);
    chk("lit_midrst_valid", int'(duty_valid_o), 0);

    // one-cycle glitch in the low phase
    pulses(10, 5, 2);
    ticks(1, 5);
    ticks(0, 2);
    ticks(1, 1);
    ticks(0, 2);
    pulses(10, 5, 1);
    ticks(0, 8);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    chk("lit_glitch_period", int'(period_o), 10);
    chk("lit_glitch_duty", int'(duty_o), 5);
`else
    chk("lit_glitch_period", int'(period_o), 7);
    chk("lit_glitch_duty", int'(duty_o), 7);
`endif

    // static low into timeout
    ticks(0, 50);
    chk("lit_low_to", int'(timeout_o), 1);
    chk("lit_low_duty", int'(duty_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
